// File: rtl/ttt_game_ctrl_if.sv
// ---------------------------------------------------------------------------
// ttt_game_ctrl_if
// Board-side bundle for the Tic-Tac-Toe sequencer.
//   switches     : raw square switches, bit 0 = A ... bit 8 = I (row-major)
//   new_game     : raw restart button
//   board_x/o    : squares owned by X / O
//   turn         : player to move (0 = X, 1 = O), meaningful in PLAY
//   game_over    : game finished (win or draw)
//   winner       : 00 none, 01 X, 10 O
//   draw         : board full with no winner
//   illegal_move : one-cycle pulse on a rejected press
// master = switch/button side, slave = the controller.
// ---------------------------------------------------------------------------
interface ttt_game_ctrl_if;
  logic [8:0] switches;
  logic       new_game;
  logic [8:0] board_x;
  logic [8:0] board_o;
  logic       turn;
  logic       game_over;
  logic [1:0] winner;
  logic       draw;
  logic       illegal_move;

  modport master (
    output switches, new_game,
    input  board_x, board_o, turn, game_over, winner, draw, illegal_move
  );

  modport slave (
    input  switches, new_game,
    output board_x, board_o, turn, game_over, winner, draw, illegal_move
  );
endinterface

// File: rtl/ttt_game_ctrl.sv
// ---------------------------------------------------------------------------
// ttt_game_ctrl
// Tic-Tac-Toe game sequencer. Synchronises and edge-detects the nine square
// switches and the new-game button, alternates X/O turns, keeps board
// occupancy, detects wins and draws, and freezes the board at game end.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : ttt_game_ctrl_if.slave (switch inputs, board/status outputs)
// Parameter START_PLAYER: player moving first after reset / new game.
// ---------------------------------------------------------------------------
module ttt_game_ctrl #(
  parameter logic START_PLAYER = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  ttt_game_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {PLAY, WIN_X, WIN_O, DRAW} state_t;

  // Eight winning lines as square masks: rows, columns, diagonals.
  localparam logic [7:0][8:0] LINE_MASKS = {
    9'h054,  // diagonal C,E,G
    9'h111,  // diagonal A,E,I
    9'h124,  // column C,F,I
    9'h092,  // column B,E,H
    9'h049,  // column A,D,G
    9'h1C0,  // row G,H,I
    9'h038,  // row D,E,F
    9'h007   // row A,B,C
  };

  state_t     r_state, w_state_next;
  logic [8:0] r_sw_s1, r_sw_s2, r_sw_prev;
  logic       r_ng_s1, r_ng_s2, r_ng_prev;
  logic [8:0] r_board_x, r_board_o, w_board_x_next, w_board_o_next;
  logic       r_turn, w_turn_next;
  logic       r_illegal, w_illegal_next;

  logic [8:0] w_sw_rise;
  logic       w_ng_rise;
  logic [7:0] w_x_line, w_o_line;
  logic       w_x_win, w_o_win, w_full;
  logic       w_rise_any, w_rise_multi, w_occupied;

  // Two-flop synchronisers plus a prev flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_s1   <= '0;
      r_sw_s2   <= '0;
      r_sw_prev <= '0;
      r_ng_s1   <= 1'b0;
      r_ng_s2   <= 1'b0;
      r_ng_prev <= 1'b0;
    end else begin
      r_sw_s1   <= bus.switches;
      r_sw_s2   <= r_sw_s1;
      r_sw_prev <= r_sw_s2;
      r_ng_s1   <= bus.new_game;
      r_ng_s2   <= r_ng_s1;
      r_ng_prev <= r_ng_s2;
    end
  end

  assign w_sw_rise = r_sw_s2 & ~r_sw_prev;
  assign w_ng_rise = r_ng_s2 & ~r_ng_prev;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_line
      assign w_x_line[gi] = ((r_board_x & LINE_MASKS[gi]) == LINE_MASKS[gi]);
      assign w_o_line[gi] = ((r_board_o & LINE_MASKS[gi]) == LINE_MASKS[gi]);
    end
  endgenerate

  assign w_x_win = |w_x_line;
  assign w_o_win = |w_o_line;
  assign w_full  = &(r_board_x | r_board_o);

  // x & (x-1) clears the lowest set bit; anything left means 2+ presses.
  assign w_rise_any   = |w_sw_rise;
  assign w_rise_multi = ((w_sw_rise & (w_sw_rise - 9'd1)) != 9'd0);
  assign w_occupied   = |(w_sw_rise & (r_board_x | r_board_o));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= PLAY;
      r_board_x <= '0;
      r_board_o <= '0;
      r_turn    <= START_PLAYER;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_board_x <= w_board_x_next;
      r_board_o <= w_board_o_next;
      r_turn    <= w_turn_next;
      r_illegal <= w_illegal_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_board_x_next = r_board_x;
    w_board_o_next = r_board_o;
    w_turn_next    = r_turn;
    w_illegal_next = 1'b0;

    if (w_ng_rise) begin
      // Restart wins over any square press landing in the same cycle.
      w_state_next   = PLAY;
      w_board_x_next = '0;
      w_board_o_next = '0;
      w_turn_next    = START_PLAYER;
    end else begin
      case (r_state)
        PLAY: begin
          // Win or full board: move to the end state, take no move.
          if (w_x_win) begin
            w_state_next = WIN_X;
          end else if (w_o_win) begin
            w_state_next = WIN_O;
          end else if (w_full) begin
            w_state_next = DRAW;
          end else if (w_rise_any) begin
            if (w_rise_multi || w_occupied) begin
              w_illegal_next = 1'b1;
            end else begin
              if (r_turn) w_board_o_next = r_board_o | w_sw_rise;
              else        w_board_x_next = r_board_x | w_sw_rise;
              w_turn_next = ~r_turn;
            end
          end
        end
        default: ;  // end states: board frozen, presses ignored silently
      endcase
    end
  end

  assign bus.board_x      = r_board_x;
  assign bus.board_o      = r_board_o;
  assign bus.turn         = r_turn;
  assign bus.game_over    = (r_state != PLAY);
  assign bus.winner       = {(r_state == WIN_O), (r_state == WIN_X)};
  assign bus.draw         = (r_state == DRAW);
  assign bus.illegal_move = r_illegal;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ttt_game_ctrl
// Scoreboard bench for ttt_game_ctrl. A behavioural game model produces the
// expected outcome of each press; it is queued when the press is driven and
// compared once the DUT has had time to respond. A second instance built
// with START_PLAYER = 1 checks the first-move owner.
// ---------------------------------------------------------------------------
module tb_ttt_game_ctrl;

  localparam logic [8:0] SQ_A = 9'h001, SQ_B = 9'h002, SQ_C = 9'h004;
  localparam logic [8:0] SQ_D = 9'h008, SQ_E = 9'h010, SQ_F = 9'h020;
  localparam logic [8:0] SQ_G = 9'h040, SQ_H = 9'h080, SQ_I = 9'h100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ttt_game_ctrl_if bus0 ();
  ttt_game_ctrl_if bus1 ();

  ttt_game_ctrl #(.START_PLAYER(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  ttt_game_ctrl #(.START_PLAYER(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      tag;
    logic [8:0] bx;
    logic [8:0] bo;
    logic       turn;
    logic       ill;
    logic       go;
    logic [1:0] win;
    logic       drw;
  } exp_t;

  exp_t sb_q[$];

  // Winning lines as square-index triples.
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  // Reference game model
  logic [8:0] m_bx, m_bo;
  logic       m_turn;
  int         m_st;   // 0 play, 1 X won, 2 O won, 3 draw

  task automatic chk_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic has_line(input logic [8:0] b);
    for (int l = 0; l < 8; l++)
      if (b[lines[l][0]] && b[lines[l][1]] && b[lines[l][2]]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_bx = '0; m_bo = '0; m_turn = 1'b0; m_st = 0;
  endtask

  task automatic model_step(input logic [8:0] sw, input logic ng, output logic ill);
    int cnt;
    ill = 1'b0;
    if (ng) begin
      model_reset();
    end else if (m_st == 0) begin
      cnt = $countones(sw);
      if (cnt == 1) begin
        if (((m_bx | m_bo) & sw) != 9'd0) ill = 1'b1;
        else begin
          if (m_turn) m_bo = m_bo | sw;
          else        m_bx = m_bx | sw;
          m_turn = ~m_turn;
        end
      end else if (cnt > 1) begin
        ill = 1'b1;
      end
    end
    if (m_st == 0) begin
      if (has_line(m_bx))          m_st = 1;
      else if (has_line(m_bo))     m_st = 2;
      else if (&(m_bx | m_bo))     m_st = 3;
    end
  endtask

  // One press on DUT0: drive for one cycle, queue the expectation, compare
  // the board once it has updated and the status one cycle after that.
  task automatic txn(input string tag, input logic [8:0] sw, input logic ng);
    exp_t e;
    exp_t got;
    logic ill;
    @(negedge clk);
    bus0.switches = sw;
    bus0.new_game = ng;
    model_step(sw, ng, ill);
    e.tag  = tag;
    e.bx   = m_bx;
    e.bo   = m_bo;
    e.turn = m_turn;
    e.ill  = ill;
    e.go   = (m_st != 0);
    e.win  = (m_st == 1) ? 2'b01 : (m_st == 2) ? 2'b10 : 2'b00;
    e.drw  = (m_st == 3);
    sb_q.push_back(e);
    @(negedge clk);
    bus0.switches = '0;
    bus0.new_game = 1'b0;
    repeat (2) @(negedge clk);
    got = sb_q.pop_front();
    chk_eq({got.tag, ".bx"},   16'(bus0.board_x),      16'(got.bx));
    chk_eq({got.tag, ".bo"},   16'(bus0.board_o),      16'(got.bo));
    chk_eq({got.tag, ".turn"}, 16'(bus0.turn),         16'(got.turn));
    chk_eq({got.tag, ".ill"},  16'(bus0.illegal_move), 16'(got.ill));
    @(negedge clk);
    chk_eq({got.tag, ".ill_end"}, 16'(bus0.illegal_move), 16'd0);
    chk_eq({got.tag, ".go"},      16'(bus0.game_over),    16'(got.go));
    chk_eq({got.tag, ".win"},     16'(bus0.winner),       16'(got.win));
    chk_eq({got.tag, ".draw"},    16'(bus0.draw),         16'(got.drw));
    $display("txn %-10s sw=%03h ng=%0b bx=%03h bo=%03h turn=%0b ill=%0b go=%0b win=%0b draw=%0b",
             got.tag, sw, ng, bus0.board_x, bus0.board_o, bus0.turn, got.ill,
             bus0.game_over, bus0.winner, bus0.draw);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus0.switches = '0; bus0.new_game = 1'b0;
    bus1.switches = '0; bus1.new_game = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk_eq("rst.bx",   16'(bus0.board_x),      16'd0);
    chk_eq("rst.bo",   16'(bus0.board_o),      16'd0);
    chk_eq("rst.turn", 16'(bus0.turn),         16'd0);
    chk_eq("rst.go",   16'(bus0.game_over),    16'd0);
    chk_eq("rst.win",  16'(bus0.winner),       16'd0);
    chk_eq("rst.draw", 16'(bus0.draw),         16'd0);
    chk_eq("rst.ill",  16'(bus0.illegal_move), 16'd0);
    chk_eq("rst.turn1", 16'(bus1.turn),        16'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Game 1: X completes the top row
    txn("g1_xA", SQ_A, 1'b0);
    chk_eq("plan.first_bx",   16'(bus0.board_x), 16'h001);
    chk_eq("plan.first_turn", 16'(bus0.turn),    16'd1);
    txn("g1_oE", SQ_E, 1'b0);
    txn("g1_xB", SQ_B, 1'b0);
    txn("g1_oF", SQ_F, 1'b0);
    txn("g1_xC", SQ_C, 1'b0);
    chk_eq("plan.win_bx",  16'(bus0.board_x), 16'h007);
    chk_eq("plan.win_win", 16'(bus0.winner),  16'h1);
    txn("g1_frzG", SQ_G, 1'b0);
    chk_eq("plan.frozen_bo", 16'(bus0.board_o), 16'h030);

    // Game 2: illegal presses
    txn("g2_new",  9'd0, 1'b1);
    txn("g2_xA",   SQ_A, 1'b0);
    txn("g2_oA",   SQ_A, 1'b0);
    txn("g2_oAB",  SQ_A | SQ_B, 1'b0);
    chk_eq("plan.ill_turn", 16'(bus0.turn), 16'd1);
    txn("g2_oE",   SQ_E, 1'b0);
    txn("g2_ngB",  SQ_B, 1'b1);
    chk_eq("plan.ng_bx",   16'(bus0.board_x), 16'd0);
    chk_eq("plan.ng_turn", 16'(bus0.turn),    16'd0);

    // Game 3: full board draw
    txn("g3_xA", SQ_A, 1'b0);
    txn("g3_oB", SQ_B, 1'b0);
    txn("g3_xC", SQ_C, 1'b0);
    txn("g3_oE", SQ_E, 1'b0);
    txn("g3_xD", SQ_D, 1'b0);
    txn("g3_oF", SQ_F, 1'b0);
    txn("g3_xH", SQ_H, 1'b0);
    txn("g3_oG", SQ_G, 1'b0);
    txn("g3_xI", SQ_I, 1'b0);
    chk_eq("plan.draw_full", 16'(bus0.board_x | bus0.board_o), 16'h1FF);
    chk_eq("plan.draw_flag", 16'(bus0.draw),   16'd1);
    chk_eq("plan.draw_win",  16'(bus0.winner), 16'd0);

    // Game 4: ninth move completes an X line
    txn("g4_new", 9'd0, 1'b1);
    txn("g4_xA", SQ_A, 1'b0);
    txn("g4_oD", SQ_D, 1'b0);
    txn("g4_xC", SQ_C, 1'b0);
    txn("g4_oE", SQ_E, 1'b0);
    txn("g4_xF", SQ_F, 1'b0);
    txn("g4_oH", SQ_H, 1'b0);
    txn("g4_xG", SQ_G, 1'b0);
    txn("g4_oI", SQ_I, 1'b0);
    txn("g4_xB", SQ_B, 1'b0);
    chk_eq("plan.ninth_win",  16'(bus0.winner), 16'h1);
    chk_eq("plan.ninth_draw", 16'(bus0.draw),   16'd0);

    // Game 5: asynchronous reset mid-game
    txn("g5_new", 9'd0, 1'b1);
    txn("g5_xA", SQ_A, 1'b0);
    txn("g5_oE", SQ_E, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("arst.bx",   16'(bus0.board_x),   16'd0);
    chk_eq("arst.bo",   16'(bus0.board_o),   16'd0);
    chk_eq("arst.turn", 16'(bus0.turn),      16'd0);
    chk_eq("arst.go",   16'(bus0.game_over), 16'd0);
    chk_eq("arst.win",  16'(bus0.winner),    16'd0);
    $display("txn %-10s async reset bx=%03h bo=%03h", "g5_arst", bus0.board_x, bus0.board_o);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    txn("g5_xI", SQ_I, 1'b0);

    // START_PLAYER = 1 instance: first press goes to O
    @(negedge clk);
    bus1.switches = SQ_A;
    @(negedge clk);
    bus1.switches = '0;
    repeat (2) @(negedge clk);
    chk_eq("sp1.bo",   16'(bus1.board_o), 16'h001);
    chk_eq("sp1.bx",   16'(bus1.board_x), 16'd0);
    chk_eq("sp1.turn", 16'(bus1.turn),    16'd0);
    $display("txn %-10s sw=%03h bx=%03h bo=%03h turn=%0b", "sp1_A", SQ_A,
             bus1.board_x, bus1.board_o, bus1.turn);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
